// File: rtl/miriscv_lsu_pkg.sv
// Shared encodings for the miriscv load-store unit: funct3 access sizes,
// FSM states and the access-legality check.
package miriscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic {LSU_IDLE = 1'b0, LSU_WAIT = 1'b1} lsu_state_t;

  // 1 when the request must be rejected: misaligned, reserved size, or unsigned store
  function automatic logic lsu_access_err(input logic       we,
                                          input logic [2:0] size,
                                          input logic [1:0] offset);
    logic err;
    case (size)
      LDST_B:  err = 1'b0;
      LDST_H:  err = offset[0];
      LDST_W:  err = (offset != 2'b00);
      LDST_BU: err = we;
      LDST_HU: err = we | offset[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/miriscv_lsu_load_align.sv
// Selects the addressed byte/half of a RAM read word and sign- or
// zero-extends it according to the load size.
module miriscv_lsu_load_align
  import miriscv_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_offset,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // lane select followed by extension
  always_comb begin
    w_byte = 8'h00;
    case (i_offset)
      2'b00:   w_byte = i_rdata[7:0];
      2'b01:   w_byte = i_rdata[15:8];
      2'b10:   w_byte = i_rdata[23:16];
      2'b11:   w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_offset[1]) begin
      w_half = i_rdata[31:16];
    end else begin
      w_half = i_rdata[15:0];
    end
    case (i_size)
      LDST_B:  o_data = {{24{w_byte[7]}}, w_byte};
      LDST_H:  o_data = {{16{w_half[15]}}, w_half};
      LDST_BU: o_data = {24'h000000, w_byte};
      LDST_HU: o_data = {16'h0000, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/miriscv_lsu.sv
// miriscv load-store unit: turns core byte/half/word requests into word-addressed,
// byte-enabled RAM accesses and stalls the core one cycle for registered reads.
module miriscv_lsu
  import miriscv_lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i
);

  lsu_state_t  r_state;
  lsu_state_t  w_state_next;
  logic [2:0]  r_size;
  logic [1:0]  r_offset;
  logic [31:0] r_hold;
  logic [31:0] w_aligned;
  logic        w_err;
  logic        w_load_go;

  assign w_err = lsu_access_err(lsu_we_i, lsu_size_i, lsu_addr_i[1:0]);

  miriscv_lsu_load_align u_load_align (
    .i_rdata  (data_rdata_i),
    .i_size   (r_size),
    .i_offset (r_offset),
    .o_data   (w_aligned)
  );

  // next-state and RAM/core handshake; reset suppresses any in-flight result
  always_comb begin
    w_state_next    = r_state;
    w_load_go       = 1'b0;
    lsu_data_o      = r_hold;
    lsu_stall_req_o = 1'b0;
    lsu_err_o       = 1'b0;
    data_req_o      = 1'b0;
    data_we_o       = 1'b0;
    data_be_o       = 4'h0;
    data_addr_o     = 32'h0000_0000;
    data_wdata_o    = 32'h0000_0000;
    if (!rst_n_i) begin
      w_state_next = LSU_IDLE;
      lsu_data_o   = 32'h0000_0000;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (lsu_req_i && w_err) begin
            lsu_err_o = 1'b1;
          end else if (lsu_req_i) begin
            data_req_o  = 1'b1;
            data_addr_o = {lsu_addr_i[31:2], 2'b00};
            if (lsu_we_i) begin
              data_we_o = 1'b1;
              case (lsu_size_i)
                LDST_B: begin
                  data_wdata_o = {4{lsu_data_i[7:0]}};
                  data_be_o    = 4'b0001 << lsu_addr_i[1:0];
                end
                LDST_H: begin
                  data_wdata_o = {2{lsu_data_i[15:0]}};
                  data_be_o    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
                end
                LDST_W: begin
                  data_wdata_o = lsu_data_i;
                  data_be_o    = 4'hF;
                end
                default: begin
                  data_wdata_o = 32'h0000_0000;
                  data_be_o    = 4'h0;
                end
              endcase
            end else begin
              data_be_o       = 4'hF;
              lsu_stall_req_o = 1'b1;
              w_load_go       = 1'b1;
              w_state_next    = LSU_WAIT;
            end
          end else begin
            w_state_next = LSU_IDLE;
          end
        end
        LSU_WAIT: begin
          lsu_data_o   = w_aligned;
          w_state_next = LSU_IDLE;
        end
        default: begin
          w_state_next = LSU_IDLE;
        end
      endcase
    end
  end

  // state, latched load attributes and result hold register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state  <= LSU_IDLE;
      r_size   <= 3'b000;
      r_offset <= 2'b00;
      r_hold   <= 32'h0000_0000;
    end else begin
      r_state <= w_state_next;
      if (w_load_go) begin
        r_size   <= lsu_size_i;
        r_offset <= lsu_addr_i[1:0];
      end
      if (r_state == LSU_WAIT) begin
        r_hold <= w_aligned;
      end
    end
  end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed self-checking bench for miriscv_lsu with a small registered-read
// byte-enabled RAM model standing in for the unified RAM.
module tb_miriscv_lsu;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o;
  logic        lsu_err_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:63];

  always #5 clk_i = ~clk_i;

  miriscv_lsu dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .lsu_req_i       (lsu_req_i),
    .lsu_we_i        (lsu_we_i),
    .lsu_size_i      (lsu_size_i),
    .lsu_addr_i      (lsu_addr_i),
    .lsu_data_i      (lsu_data_i),
    .lsu_data_o      (lsu_data_o),
    .lsu_stall_req_o (lsu_stall_req_o),
    .lsu_err_o       (lsu_err_o),
    .data_req_o      (data_req_o),
    .data_we_o       (data_we_o),
    .data_be_o       (data_be_o),
    .data_addr_o     (data_addr_o),
    .data_wdata_o    (data_wdata_o),
    .data_rdata_i    (data_rdata_i)
  );

  // RAM model: byte-enabled write, registered read
  always @(posedge clk_i) begin
    if (data_req_o && data_we_o) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_o[b]) mem[data_addr_o[7:2]][b*8 +: 8] <= data_wdata_o[b*8 +: 8];
      end
    end else if (data_req_o) begin
      data_rdata_i <= mem[data_addr_o[7:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] data);
    lsu_req_i  = req;
    lsu_we_i   = we;
    lsu_size_i = size;
    lsu_addr_i = addr;
    lsu_data_i = data;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_store(input string tag, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata);
    drive(1'b1, 1'b1, size, addr, data);
    @(negedge clk_i);
    check({tag, "_req"},   {31'd0, data_req_o}, 32'd1);
    check({tag, "_we"},    {31'd0, data_we_o}, 32'd1);
    check({tag, "_be"},    {28'd0, data_be_o}, {28'd0, exp_be});
    check({tag, "_wdata"}, data_wdata_o, exp_wdata);
    check({tag, "_addr"},  data_addr_o, {addr[31:2], 2'b00});
    check({tag, "_stall"}, {31'd0, lsu_stall_req_o}, 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  // issue cycle then WAIT cycle; request is held through WAIT as a stalled core would
  task automatic do_load(input string tag, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] exp);
    drive(1'b1, 1'b0, size, addr, 32'h0);
    @(negedge clk_i);
    check({tag, "_stall1"}, {31'd0, lsu_stall_req_o}, 32'd1);
    check({tag, "_req1"},   {31'd0, data_req_o}, 32'd1);
    check({tag, "_be"},     {28'd0, data_be_o}, 32'hF);
    check({tag, "_addr"},   data_addr_o, {addr[31:2], 2'b00});
    next_cycle();
    @(negedge clk_i);
    check({tag, "_stall2"}, {31'd0, lsu_stall_req_o}, 32'd0);
    check({tag, "_req2"},   {31'd0, data_req_o}, 32'd0);
    check({tag, "_data"},   lsu_data_o, exp);
    next_cycle();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic do_err(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] exp_hold);
    drive(1'b1, we, size, addr, 32'h1111_1111);
    @(negedge clk_i);
    check({tag, "_err"},   {31'd0, lsu_err_o}, 32'd1);
    check({tag, "_req"},   {31'd0, data_req_o}, 32'd0);
    check({tag, "_stall"}, {31'd0, lsu_stall_req_o}, 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk_i);
    check({tag, "_errpulse"}, {31'd0, lsu_err_o}, 32'd0);
    check({tag, "_hold"},     lsu_data_o, exp_hold);
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    data_rdata_i = 32'h0;
    rst_n_i = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    next_cycle();
    next_cycle();
    @(negedge clk_i);
    check("rst_data",  lsu_data_o, 32'h0);
    check("rst_stall", {31'd0, lsu_stall_req_o}, 32'd0);
    check("rst_req",   {31'd0, data_req_o}, 32'd0);
    check("rst_err",   {31'd0, lsu_err_o}, 32'd0);
    next_cycle();
    rst_n_i = 1'b1;
    next_cycle();

    // 1: word store / load
    do_store("sw10", 3'b010, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF);
    do_load("lw10", 3'b010, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk_i);
    check("idle_hold", lsu_data_o, 32'hDEAD_BEEF);
    check("idle_req",  {31'd0, data_req_o}, 32'd0);
    check("idle_be",   {28'd0, data_be_o}, 32'd0);
    next_cycle();

    // 2: byte store into lane 3, signed/unsigned byte loads
    do_store("sb13", 3'b000, 32'h13, 32'h0000_0080, 4'b1000, 32'h8080_8080);
    do_load("lb13",  3'b000, 32'h13, 32'hFFFF_FF80);
    do_load("lbu13", 3'b100, 32'h13, 32'h0000_0080);
    do_load("lbu12", 3'b100, 32'h12, 32'h0000_00AD);

    // 3: upper half store, signed/unsigned half loads
    do_store("sh22", 3'b001, 32'h22, 32'h0000_8001, 4'b1100, 32'h8001_8001);
    do_load("lh22",  3'b001, 32'h22, 32'hFFFF_8001);
    do_load("lhu22", 3'b101, 32'h22, 32'h0000_8001);

    // 4: misaligned and illegal accesses; hold reg keeps last result
    do_err("lw21",   1'b0, 3'b010, 32'h21, 32'h0000_8001);
    do_err("lh23",   1'b0, 3'b001, 32'h23, 32'h0000_8001);
    do_err("sbu10",  1'b1, 3'b100, 32'h10, 32'h0000_8001);
    do_err("size011",1'b0, 3'b011, 32'h10, 32'h0000_8001);
    do_load("lw10b", 3'b010, 32'h10, 32'h80AD_BEEF);
    do_load("lw20",  3'b010, 32'h20, 32'h8001_0000);

    // 5: back-to-back loads
    do_store("sw14", 3'b010, 32'h14, 32'h1234_5678, 4'hF, 32'h1234_5678);
    do_load("b2b_a", 3'b010, 32'h10, 32'h80AD_BEEF);
    do_load("b2b_b", 3'b010, 32'h14, 32'h1234_5678);

    // 6: reset during WAIT drops the result
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    next_cycle();
    rst_n_i = 1'b0;
    @(negedge clk_i);
    check("rstw_data",  lsu_data_o, 32'h0);
    check("rstw_stall", {31'd0, lsu_stall_req_o}, 32'd0);
    next_cycle();
    rst_n_i = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk_i);
    check("rsta_data",  lsu_data_o, 32'h0);
    check("rsta_stall", {31'd0, lsu_stall_req_o}, 32'd0);
    check("rsta_req",   {31'd0, data_req_o}, 32'd0);
    next_cycle();
    do_load("post_rst", 3'b010, 32'h14, 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
